traffic_light_ctrl: RTL and testbench

TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

---
 rtl/traffic_pkg.sv | 50 +++++
 rtl/tick_gen.sv | 43 ++++
 rtl/traffic_light_ctrl.sv | 130 +++++++++++++
 tb/tb_traffic_light_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_pkg
//  Description : Shared types and constants for the traffic light controller:
//                the six-state phase enum, lamp encodings, the pedestrian
//                shortening value and small helper functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    typedef enum logic [2:0] {
        ALL_RED_A = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        ALL_RED_B = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5
    } state_t;

    // Lamp vectors are {red, yellow, green}
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    // Remaining NS green seconds once a pedestrian request is pending
    localparam logic [3:0] PED_SHORT_T = 4'd3;

    // Largest value a single BCD digit can show
    localparam logic [3:0] BCD_MAX = 4'd9;

    // Fixed phase rotation; any unused encoding recovers to ALL_RED_A
    function automatic state_t next_state(input state_t s);
        case (s)
            ALL_RED_A: next_state = NS_GREEN;
            NS_GREEN:  next_state = NS_YELLOW;
            NS_YELLOW: next_state = ALL_RED_B;
            ALL_RED_B: next_state = EW_GREEN;
            EW_GREEN:  next_state = EW_YELLOW;
            EW_YELLOW: next_state = ALL_RED_A;
            default:   next_state = ALL_RED_A;
        endcase
    endfunction

    // Keeps an out-of-range start value from ever producing a non-BCD digit
    function automatic logic [3:0] clamp_bcd(input int unsigned v);
        clamp_bcd = (v > 32'd9) ? BCD_MAX : 4'(v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : Free-running prescaler producing a one-clock tick every
//                TICK_DIV clocks. The tick is registered and asserted during
//                the cycle in which the counter holds TICK_DIV-1, so the first
//                tick is consumed on the TICK_DIV-th edge after reset release.
//  Ports       : clk   - system clock (rising edge)
//                reset - synchronous active-high reset
//                tick  - one-clock pulse per TICK_DIV clocks
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int unsigned TICK_DIV = 100000000   // minimum 2
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned          c_cnt_w   = $clog2(TICK_DIV);
    localparam logic [c_cnt_w-1:0]   c_cnt_max = c_cnt_w'(TICK_DIV - 1);
    // Tick is registered, so it is armed one count before the wrap
    localparam logic [c_cnt_w-1:0]   c_cnt_pre = c_cnt_w'(TICK_DIV - 2);
    localparam logic [c_cnt_w-1:0]   c_cnt_one = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_cnt == c_cnt_pre);
            r_cnt  <= (r_cnt == c_cnt_max) ? '0 : (r_cnt + c_cnt_one);
        end
    end

    assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_light_ctrl
//  Description : Two-way intersection controller. Cycles ALL_RED_A, NS_GREEN,
//                NS_YELLOW, ALL_RED_B, EW_GREEN, EW_YELLOW with a BCD seconds
//                countdown; a latched pedestrian request shortens the NS green
//                phase to PED_SHORT_T remaining seconds.
//  Ports       : clk       - system clock (rising edge)
//                reset     - synchronous active-high reset
//                ped_req   - pedestrian request, single-cycle pulse suffices
//                ns_lights - north-south lamps {red, yellow, green}, registered
//                ew_lights - east-west lamps {red, yellow, green}, registered
//                count_bcd - remaining seconds, BCD digit 0..9, registered
//                ped_wait  - high while a pedestrian request is latched
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100000000,
    parameter int unsigned GREEN_T  = 9,
    parameter int unsigned YELLOW_T = 3,
    parameter int unsigned RED_T    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ped_req,
    output logic [2:0] ns_lights,
    output logic [2:0] ew_lights,
    output logic [3:0] count_bcd,
    output logic       ped_wait
);

    localparam logic [3:0] c_green_start  = clamp_bcd(GREEN_T);
    localparam logic [3:0] c_yellow_start = clamp_bcd(YELLOW_T);
    localparam logic [3:0] c_red_start    = clamp_bcd(RED_T);

    function automatic logic [3:0] start_of(input state_t s);
        case (s)
            NS_GREEN, EW_GREEN:   start_of = c_green_start;
            NS_YELLOW, EW_YELLOW: start_of = c_yellow_start;
            default:              start_of = c_red_start;
        endcase
    endfunction

    logic       w_tick;

    state_t     r_state;
    logic [3:0] r_count;
    logic       r_ped;
    logic [2:0] r_ns;
    logic [2:0] r_ew;

    state_t     w_state_nxt;
    logic [3:0] w_count_nxt;
    logic       w_ped_nxt;
    logic       w_enter_yel;
    logic [2:0] w_ns_nxt;
    logic [2:0] w_ew_nxt;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    // State register: phase, countdown, pedestrian latch and lamp registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ALL_RED_A;
            r_count <= c_red_start;
            r_ped   <= 1'b0;
            r_ns    <= LAMP_RED;
            r_ew    <= LAMP_RED;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_ped   <= w_ped_nxt;
            r_ns    <= w_ns_nxt;
            r_ew    <= w_ew_nxt;
        end
    end

    // Next-state and countdown logic; everything only moves on a tick
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        if (w_tick) begin
            if (r_count == 4'd0) begin
                w_state_nxt = next_state(r_state);
                w_count_nxt = start_of(w_state_nxt);
            end else if ((r_state == NS_GREEN) && r_ped && (r_count > PED_SHORT_T)) begin
                w_count_nxt = PED_SHORT_T;
            end else begin
                w_count_nxt = r_count - 4'd1;
            end
        end

        // Leaving NS green serves the request; a request arriving on that
        // same edge is deliberately dropped
        w_enter_yel = w_tick && (r_state == NS_GREEN) && (r_count == 4'd0);
        w_ped_nxt   = w_enter_yel ? 1'b0 : (r_ped | ped_req);
    end

    // Lamp decode from the upcoming state so lamps change on the same edge
    // as the state and are themselves registered
    always_comb begin
        w_ns_nxt = LAMP_RED;
        w_ew_nxt = LAMP_RED;
        case (w_state_nxt)
            NS_GREEN:  w_ns_nxt = LAMP_GRN;
            NS_YELLOW: w_ns_nxt = LAMP_YEL;
            EW_GREEN:  w_ew_nxt = LAMP_GRN;
            EW_YELLOW: w_ew_nxt = LAMP_YEL;
            default: begin
                w_ns_nxt = LAMP_RED;
                w_ew_nxt = LAMP_RED;
            end
        endcase
    end

    assign ns_lights = r_ns;
    assign ew_lights = r_ew;
    assign count_bcd = r_count;
    assign ped_wait  = r_ped;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_traffic_light_ctrl
//  Description : Directed self-checking bench for traffic_light_ctrl with
//                TICK_DIV=4, GREEN_T=9, YELLOW_T=3, RED_T=1. Edge numbers are
//                counted from the last reset edge; expected values are
//                hand-derived from the phase timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_light_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       ped_req;
    logic [2:0] ns_lights;
    logic [2:0] ew_lights;
    logic [3:0] count_bcd;
    logic       ped_wait;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;
    int n_viol   = 0;

    traffic_light_ctrl #(
        .TICK_DIV (4),
        .GREEN_T  (9),
        .YELLOW_T (3),
        .RED_T    (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ped_req   (ped_req),
        .ns_lights (ns_lights),
        .ew_lights (ew_lights),
        .count_bcd (count_bcd),
        .ped_wait  (ped_wait)
    );

    always #5 clk = ~clk;

    // Lamp safety watch: one-hot per direction, never both non-red
    always @(negedge clk) begin
        if (!$onehot(ns_lights) || !$onehot(ew_lights) ||
            ((ns_lights != 3'b100) && (ew_lights != 3'b100)))
            n_viol++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) step();
    endtask

    task automatic pulse_ped();
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
    endtask

    int          chg_edge[$];
    logic [5:0]  chg_lamp[$];
    logic [5:0]  prev;
    int          exp_ticks[6] = '{10, 4, 2, 10, 4, 2};
    logic [5:0]  exp_lamp[6]  = '{6'b010_100, 6'b100_100, 6'b100_001,
                                  6'b100_010, 6'b100_100, 6'b001_100};

    initial begin
        reset   = 1'b1;
        ped_req = 1'b0;
        repeat (3) step();
        check_eq("rst_ns", ns_lights, 3'b100);
        check_eq("rst_ew", ew_lights, 3'b100);
        check_eq("rst_count", count_bcd, 4'd1);
        check_eq("rst_ped", ped_wait, 1'b0);

        // Reset dominates a pending ped_req
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        check_eq("rst_ped_prio", ped_wait, 1'b0);

        reset  = 1'b0;
        edge_n = 0;

        run_to(3);  check_eq("hold_pre_tick", count_bcd, 4'd1);
        run_to(4);  check_eq("tick4_count", count_bcd, 4'd0);
        run_to(7);  check_eq("hold_e7_count", count_bcd, 4'd0);
                    check_eq("hold_e7_ns", ns_lights, 3'b100);
        run_to(8);  check_eq("e8_ns", ns_lights, 3'b001);
                    check_eq("e8_ew", ew_lights, 3'b100);
                    check_eq("e8_count", count_bcd, 4'd9);

        // One full cycle: record lamp changes over 128 clocks
        prev = {ns_lights, ew_lights};
        for (int i = 0; i < 128; i++) begin
            step();
            if ({ns_lights, ew_lights} != prev) begin
                chg_edge.push_back(edge_n - 8);
                chg_lamp.push_back({ns_lights, ew_lights});
                prev = {ns_lights, ew_lights};
            end
        end
        check_eq("cycle_changes", chg_edge.size(), 6);
        for (int i = 0; i < 6; i++) begin
            int   d;
            logic [5:0] l;
            if (i < chg_edge.size()) begin
                d = (chg_edge[i] - ((i == 0) ? 0 : chg_edge[i-1])) / 4;
                l = chg_lamp[i];
            end else begin
                d = -1;
                l = 6'h3f;
            end
            check_eq($sformatf("phase%0d_ticks", i), d, exp_ticks[i]);
            check_eq($sformatf("phase%0d_lamps", i), l, exp_lamp[i]);
        end
        check_eq("cycle_end_count", count_bcd, 4'd9);

        // Pedestrian request at NS green count 7
        run_to(144); check_eq("ped1_pre_count", count_bcd, 4'd7);
        pulse_ped();
        check_eq("ped1_wait", ped_wait, 1'b1);
        check_eq("ped1_hold_count", count_bcd, 4'd7);
        run_to(148); check_eq("ped1_short", count_bcd, 4'd3);
        run_to(152); check_eq("ped1_c2", count_bcd, 4'd2);
        run_to(160); check_eq("ped1_c0", count_bcd, 4'd0);
        run_to(164); check_eq("ped1_yel_ns", ns_lights, 3'b010);
                     check_eq("ped1_yel_count", count_bcd, 4'd3);
                     check_eq("ped1_clear", ped_wait, 1'b0);

        // Request during EW green held until next NS green
        run_to(199);
        pulse_ped();
        check_eq("ped2_ew", ew_lights, 3'b001);
        check_eq("ped2_wait", ped_wait, 1'b1);
        run_to(252); check_eq("ped2_nsg_ns", ns_lights, 3'b001);
                     check_eq("ped2_nsg_count", count_bcd, 4'd9);
                     check_eq("ped2_held", ped_wait, 1'b1);
        run_to(256); check_eq("ped2_short", count_bcd, 4'd3);
        // Request coinciding with NS yellow entry: clear wins
        run_to(271);
        pulse_ped();
        check_eq("ped3_yel_ns", ns_lights, 3'b010);
        check_eq("ped3_clear_wins", ped_wait, 1'b0);

        // Reset during EW yellow at count 2 with a request pending
        run_to(319);
        pulse_ped();
        check_eq("ped4_wait", ped_wait, 1'b1);
        run_to(340); check_eq("ewy_ew", ew_lights, 3'b010);
                     check_eq("ewy_count", count_bcd, 4'd2);
        reset = 1'b1;
        step();
        check_eq("mid_rst_ns", ns_lights, 3'b100);
        check_eq("mid_rst_ew", ew_lights, 3'b100);
        check_eq("mid_rst_count", count_bcd, 4'd1);
        check_eq("mid_rst_ped", ped_wait, 1'b0);
        reset  = 1'b0;
        edge_n = 0;

        run_to(3);  check_eq("r2_hold", count_bcd, 4'd1);
        run_to(4);  check_eq("r2_tick4", count_bcd, 4'd0);

        // Request at NS green count 2: normal countdown
        run_to(36); check_eq("ped5_ns", ns_lights, 3'b001);
                    check_eq("ped5_pre_count", count_bcd, 4'd2);
        pulse_ped();
        check_eq("ped5_wait", ped_wait, 1'b1);
        run_to(40); check_eq("ped5_c1", count_bcd, 4'd1);
        run_to(44); check_eq("ped5_c0", count_bcd, 4'd0);
        run_to(48); check_eq("ped5_yel_ns", ns_lights, 3'b010);
                    check_eq("ped5_yel_count", count_bcd, 4'd3);
                    check_eq("ped5_clear", ped_wait, 1'b0);

        check_eq("lamp_safety_violations", n_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
